// File: rtl/lpm_compare_sched_pkg.sv
// Shared definitions for the round-robin comparator scheduler.
// Contents:
//   FLAG_* : bit positions inside the 6-bit relation flag vector
//            {alb, aeb, agb, aleb, aneb, ageb}
//   REP_*  : allowed values of the LPM_REPRESENTATION parameter
//   clog2  : minimum width (at least 1) of a field holding 0..value-1
package lpm_sched_pkg;

  localparam int NUM_FLAGS = 6;
  localparam int FLAG_ALB  = 5;
  localparam int FLAG_AEB  = 4;
  localparam int FLAG_AGB  = 3;
  localparam int FLAG_ALEB = 2;
  localparam int FLAG_ANEB = 1;
  localparam int FLAG_AGEB = 0;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  // Never returns 0 so that it can size a vector even for value <= 2.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    if (width == 0) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/lpm_compare_sched_if.sv
// Request/response bundle between the comparator clients and the scheduler.
// Signals:
//   req_valid  [NUM_REQ]            per-requester operand valid
//   req_ready  [NUM_REQ]            one-hot grant from the scheduler
//   req_dataa  [NUM_REQ*LPM_WIDTH]  packed A operands, requester i at [i*LPM_WIDTH +: LPM_WIDTH]
//   req_datab  [NUM_REQ*LPM_WIDTH]  packed B operands, same packing
//   rsp_valid                       result strobe
//   rsp_id     [clog2(NUM_REQ)]     requester that owns the result
//   rsp_flags  [6]                  {alb, aeb, agb, aleb, aneb, ageb}
// Modports: master = client side, slave = scheduler side.
interface lpm_compare_sched_if
  import lpm_sched_pkg::*;
#(
  parameter int LPM_WIDTH = 8,
  parameter int NUM_REQ   = 4
);

  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*LPM_WIDTH-1:0] req_dataa;
  logic [NUM_REQ*LPM_WIDTH-1:0] req_datab;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [NUM_FLAGS-1:0]         rsp_flags;

  modport master (
    output req_valid, req_dataa, req_datab,
    input  req_ready, rsp_valid, rsp_id, rsp_flags
  );

  modport slave (
    input  req_valid, req_dataa, req_datab,
    output req_ready, rsp_valid, rsp_id, rsp_flags
  );

endinterface

// File: rtl/lpm_compare_pipe.sv
// Magnitude comparator followed by LPM_PIPELINE register stages carrying
// valid, requester id and the six relation flags.
// Ports:
//   clock, aclr_n    clock and asynchronous active-low reset
//   clken            stages advance only while high
//   in_valid/in_id   launch-stage valid bit and requester id
//   in_a/in_b        launch-stage operands
//   out_valid        last-stage valid (not gated by clken)
//   out_id/out_flags last-stage id and flags
module lpm_compare_pipe
  import lpm_sched_pkg::*;
#(
  parameter int    LPM_WIDTH          = 8,
  parameter int    NUM_REQ            = 4,
  parameter int    LPM_PIPELINE       = 2,
  parameter string LPM_REPRESENTATION = "UNSIGNED",
  localparam int   ID_W               = clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 clken,
  input  logic                 in_valid,
  input  logic [ID_W-1:0]      in_id,
  input  logic [LPM_WIDTH-1:0] in_a,
  input  logic [LPM_WIDTH-1:0] in_b,
  output logic                 out_valid,
  output logic [ID_W-1:0]      out_id,
  output logic [NUM_FLAGS-1:0] out_flags
);

  localparam bit IS_SIGNED = (LPM_REPRESENTATION == REP_SIGNED);

  logic [LPM_WIDTH-1:0] cmp_a;
  logic [LPM_WIDTH-1:0] cmp_b;
  logic                 alb;
  logic                 aeb;
  logic                 agb;
  logic [NUM_FLAGS-1:0] flags;

  // Two's complement ordering equals unsigned ordering once the sign bits
  // are inverted, so one unsigned comparator serves both representations.
  always_comb begin
    cmp_a = in_a;
    cmp_b = in_b;
    if (IS_SIGNED) begin
      cmp_a[LPM_WIDTH-1] = ~in_a[LPM_WIDTH-1];
      cmp_b[LPM_WIDTH-1] = ~in_b[LPM_WIDTH-1];
    end
    alb = (cmp_a < cmp_b);
    aeb = (cmp_a == cmp_b);
    agb = (cmp_a > cmp_b);
    flags            = '0;
    flags[FLAG_ALB]  = alb;
    flags[FLAG_AEB]  = aeb;
    flags[FLAG_AGB]  = agb;
    flags[FLAG_ALEB] = alb | aeb;
    flags[FLAG_ANEB] = ~aeb;
    flags[FLAG_AGEB] = agb | aeb;
  end

  generate
    if (LPM_PIPELINE == 0) begin : g_comb
      assign out_valid = in_valid;
      assign out_id    = in_id;
      assign out_flags = flags;
    end else begin : g_regs
      logic [LPM_PIPELINE:1] stage_valid;
      logic [ID_W-1:0]       stage_id    [1:LPM_PIPELINE];
      logic [NUM_FLAGS-1:0]  stage_flags [1:LPM_PIPELINE];

      // Data fields load only behind a valid bit, so the last stage always
      // keeps the most recent real result rather than bubble contents.
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          stage_valid <= '0;
          for (int s = 1; s <= LPM_PIPELINE; s++) begin
            stage_id[s]    <= '0;
            stage_flags[s] <= '0;
          end
        end else if (clken) begin
          stage_valid[1] <= in_valid;
          if (in_valid) begin
            stage_id[1]    <= in_id;
            stage_flags[1] <= flags;
          end
          for (int s = 2; s <= LPM_PIPELINE; s++) begin
            stage_valid[s] <= stage_valid[s-1];
            if (stage_valid[s-1]) begin
              stage_id[s]    <= stage_id[s-1];
              stage_flags[s] <= stage_flags[s-1];
            end
          end
        end
      end

      assign out_valid = stage_valid[LPM_PIPELINE];
      assign out_id    = stage_id[LPM_PIPELINE];
      assign out_flags = stage_flags[LPM_PIPELINE];
    end
  endgenerate

endmodule

// File: rtl/lpm_compare_sched.sv
// Round-robin scheduler sharing one pipelined magnitude comparator among
// NUM_REQ requesters. At most one requester is granted per enabled cycle;
// its operands go through the comparator and come back as the six relation
// flags tagged with the requester id, LPM_PIPELINE+1 enabled cycles later.
// Ports:
//   clock      sole clock, rising edge
//   aclr_n     asynchronous active-low reset
//   clken      global enable; low freezes arbitration and pipeline
//   bus        request/response bundle (slave side)
//   in_flight  launched operations not yet returned
module lpm_compare_sched
  import lpm_sched_pkg::*;
#(
  parameter int    LPM_WIDTH          = 8,
  parameter int    NUM_REQ            = 4,
  parameter int    LPM_PIPELINE       = 2,
  parameter string LPM_REPRESENTATION = "UNSIGNED"
) (
  input  logic                                 clock,
  input  logic                                 aclr_n,
  input  logic                                 clken,
  lpm_compare_sched_if.slave                   bus,
  output logic [clog2(LPM_PIPELINE+2)-1:0]     in_flight
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(LPM_PIPELINE + 2);

  generate
    if (!((LPM_REPRESENTATION == REP_UNSIGNED) || (LPM_REPRESENTATION == REP_SIGNED)) ||
        (NUM_REQ < 2) || (NUM_REQ > 16) || (LPM_PIPELINE < 0) || (LPM_PIPELINE > 8)) begin : g_bad_params
      $error("lpm_compare_sched: unsupported LPM_REPRESENTATION, NUM_REQ or LPM_PIPELINE");
    end
  endgenerate

  logic [ID_W-1:0]      ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 handshake;

  logic                 s0_valid;
  logic [ID_W-1:0]      s0_id;
  logic [LPM_WIDTH-1:0] s0_a;
  logic [LPM_WIDTH-1:0] s0_b;

  logic                 last_valid;
  logic [ID_W-1:0]      last_id;
  logic [NUM_FLAGS-1:0] last_flags;
  logic [ID_W-1:0]      held_id;
  logic [NUM_FLAGS-1:0] held_flags;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Search starts just after the last granted requester so every active
  // requester gets a turn before anyone is served twice.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if ((grant == '0) && bus.req_valid[wrap_add(ptr, k)]) begin
        grant[wrap_add(ptr, k)] = 1'b1;
        grant_id                = wrap_add(ptr, k);
      end
    end
  end

  assign bus.req_ready = (clken && aclr_n) ? grant : '0;
  assign handshake     = |(bus.req_valid & bus.req_ready);

  // Reset parks the pointer on the last index so requester 0 wins first.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (clken && handshake) begin
      ptr <= grant_id;
    end
  end

  // Launch register: operands are captured only on the handshake edge, so
  // a client may change its data freely afterwards.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s0_valid <= 1'b0;
      s0_id    <= '0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else if (clken) begin
      s0_valid <= handshake;
      if (handshake) begin
        s0_id <= grant_id;
        s0_a  <= bus.req_dataa[int'(grant_id)*LPM_WIDTH +: LPM_WIDTH];
        s0_b  <= bus.req_datab[int'(grant_id)*LPM_WIDTH +: LPM_WIDTH];
      end
    end
  end

  lpm_compare_pipe #(
    .LPM_WIDTH          (LPM_WIDTH),
    .NUM_REQ            (NUM_REQ),
    .LPM_PIPELINE       (LPM_PIPELINE),
    .LPM_REPRESENTATION (LPM_REPRESENTATION)
  ) u_pipe (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .clken     (clken),
    .in_valid  (s0_valid),
    .in_id     (s0_id),
    .in_a      (s0_a),
    .in_b      (s0_b),
    .out_valid (last_valid),
    .out_id    (last_id),
    .out_flags (last_flags)
  );

  // Gating with clken makes each result visible for exactly one enabled
  // cycle, because the last stage only drains while clken is high.
  assign bus.rsp_valid = last_valid & clken;

  // Remembers the last presented result so id/flags stay put between
  // strobes, including while a new result waits in a stalled last stage.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      held_id    <= '0;
      held_flags <= '0;
    end else if (bus.rsp_valid) begin
      held_id    <= last_id;
      held_flags <= last_flags;
    end
  end

  assign bus.rsp_id    = bus.rsp_valid ? last_id    : held_id;
  assign bus.rsp_flags = bus.rsp_valid ? last_flags : held_flags;

  // Launch and retire in the same cycle cancel; both are zero while
  // clken is low, which freezes the count.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      in_flight <= '0;
    end else if (handshake && !bus.rsp_valid) begin
      in_flight <= in_flight + CNT_W'(1);
    end else if (bus.rsp_valid && !handshake) begin
      in_flight <= in_flight - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lpm_compare_sched.sv
// Self-checking bench for lpm_compare_sched: one UNSIGNED instance checked
// through a scoreboard plus per-test inline checks, and one SIGNED instance
// for the two's complement compare.
module tb_lpm_compare_sched;

  localparam int W = 8;
  localparam int N = 4;
  localparam int P = 2;

  logic       clock = 1'b0;
  logic       aclr_n;
  logic       clken;
  logic [1:0] in_flight;
  logic [1:0] in_flight_s;

  always #5 clock = ~clock;

  lpm_compare_sched_if #(.LPM_WIDTH(W), .NUM_REQ(N)) bus ();
  lpm_compare_sched_if #(.LPM_WIDTH(W), .NUM_REQ(N)) bus_s ();

  lpm_compare_sched #(
    .LPM_WIDTH(W), .NUM_REQ(N), .LPM_PIPELINE(P), .LPM_REPRESENTATION("UNSIGNED")
  ) dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(bus.slave), .in_flight(in_flight)
  );

  lpm_compare_sched #(
    .LPM_WIDTH(W), .NUM_REQ(N), .LPM_PIPELINE(P), .LPM_REPRESENTATION("SIGNED")
  ) dut_s (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(bus_s.slave), .in_flight(in_flight_s)
  );

  typedef struct {
    logic [1:0] id;
    logic [5:0] flags;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] rsp_log[$];
  int         errors   = 0;
  int         checks   = 0;
  int         en_cycle = 0;

  // Reference relation flags {alb, aeb, agb, aleb, aneb, ageb}.
  function automatic logic [5:0] model_flags(input logic [7:0] a, input logic [7:0] b, input bit is_signed);
    logic lt, eq, gt;
    if (is_signed) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
    eq = (a == b);
    return {lt, eq, gt, lt | eq, !eq, gt | eq};
  endfunction

  // Scoreboard: pushes expected results on each observed handshake and
  // checks each response against them, including the enabled-cycle latency.
  always begin : monitor
    exp_t e;
    exp_t n;
    @(negedge clock);
    #3;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      rsp_log.push_back(bus.rsp_id);
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL rsp_unexpected: got id=%0d flags=%b, required no response", bus.rsp_id, bus.rsp_flags);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_id !== e.id || bus.rsp_flags !== e.flags || en_cycle != e.due) begin
          errors++;
          $display("[TB] FAIL rsp_match: got id=%0d flags=%b cycle=%0d, required id=%0d flags=%b cycle=%0d",
                   bus.rsp_id, bus.rsp_flags, en_cycle, e.id, e.flags, e.due);
        end
      end
    end
    if ((bus.req_valid & bus.req_ready) != '0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          n.id    = 2'(i);
          n.flags = model_flags(bus.req_dataa[i*W +: W], bus.req_datab[i*W +: W], 1'b0);
          n.due   = en_cycle + P + 1;
          sb.push_back(n);
        end
      end
    end
    if (clken === 1'b1) en_cycle++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_req(input int idx, input logic v, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[idx]       = v;
    bus.req_dataa[idx*W +: W] = a;
    bus.req_datab[idx*W +: W] = b;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 0000", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id); end
    checks++;
    if (bus.rsp_flags !== 6'b0) begin errors++; $display("[TB] FAIL reset_rsp_flags: got %b, required 000000", bus.rsp_flags); end
    checks++;
    if (in_flight !== 2'd0) begin errors++; $display("[TB] FAIL reset_in_flight: got %0d, required 0", in_flight); end
    bus.req_valid = '0;
    aclr_n = 1'b1;
  endtask

  task automatic test_round_robin();
    rsp_log.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(c*16 + i), 8'($urandom_range(0, 255)));
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << (c % 4))) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, required %b", c, bus.req_ready, 4'(1 << (c % 4)));
      end
      checks++;
      if (in_flight !== 2'((c < 3) ? c : 3)) begin
        errors++;
        $display("[TB] FAIL rr_in_flight[%0d]: got %0d, required %0d", c, in_flight, (c < 3) ? c : 3);
      end
    end
    @(negedge clock);
    bus.req_valid = '0;
    drain();
    checks++;
    if (rsp_log.size() != 8) begin
      errors++;
      $display("[TB] FAIL rr_rsp_count: got %0d, required 8", rsp_log.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (rsp_log[j] !== 2'(j % 4)) begin
          errors++;
          $display("[TB] FAIL rr_rsp_id[%0d]: got %0d, required %0d", j, rsp_log[j], j % 4);
        end
      end
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    set_req(1, 1'b1, 8'h05, 8'h09);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL single_ready: got %b, required 0010", bus.req_ready); end
    @(negedge clock);
    set_req(1, 1'b0, 8'hFF, 8'h00);
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0 || in_flight !== 2'd1) begin
      errors++;
      $display("[TB] FAIL single_t1: got rsp_valid=%b in_flight=%0d, required 0 and 1", bus.rsp_valid, in_flight);
    end
    @(negedge clock);
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_t2: got rsp_valid=%b, required 0", bus.rsp_valid); end
    @(negedge clock);
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_flags !== 6'b100110) begin
      errors++;
      $display("[TB] FAIL single_t3: got valid=%b id=%0d flags=%b, required 1 1 100110", bus.rsp_valid, bus.rsp_id, bus.rsp_flags);
    end
    @(negedge clock);
    #2;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd1 || bus.rsp_flags !== 6'b100110 || in_flight !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_hold: got valid=%b id=%0d flags=%b in_flight=%0d, required 0 1 100110 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flags, in_flight);
    end
    drain();
  endtask

  task automatic test_signed();
    int         got_s;
    int         got_u;
    logic [1:0] id_s;
    logic [5:0] flags_s;
    logic [5:0] flags_u;
    got_s = 0; got_u = 0; id_s = '0; flags_s = '0; flags_u = '0;
    @(negedge clock);
    bus_s.req_valid[0]   = 1'b1;
    bus_s.req_dataa[7:0] = 8'hFE;
    bus_s.req_datab[7:0] = 8'h01;
    set_req(2, 1'b1, 8'hFE, 8'h01);
    #1;
    checks++;
    if (bus_s.req_ready !== 4'b0001 || bus.req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL signed_ready: got %b/%b, required 0001/0100", bus_s.req_ready, bus.req_ready);
    end
    @(negedge clock);
    bus_s.req_valid = '0;
    bus.req_valid   = '0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (bus_s.rsp_valid === 1'b1) begin got_s++; id_s = bus_s.rsp_id; flags_s = bus_s.rsp_flags; end
      if (bus.rsp_valid === 1'b1) begin got_u++; flags_u = bus.rsp_flags; end
      @(negedge clock);
    end
    checks++;
    if (got_s != 1 || id_s !== 2'd0 || flags_s !== 6'b100110) begin
      errors++;
      $display("[TB] FAIL signed_flags: got count=%0d id=%0d flags=%b, required 1 0 100110", got_s, id_s, flags_s);
    end
    checks++;
    if (got_u != 1 || flags_u !== 6'b001011) begin
      errors++;
      $display("[TB] FAIL unsigned_flags: got count=%0d flags=%b, required 1 001011", got_u, flags_u);
    end
    drain();
  endtask

  task automatic test_stall();
    rsp_log.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      set_req(2, 1'b1, 8'(8'h10 + c), 8'(8'h11 - c));
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL stall_launch[%0d]: got %b, required 0100", c, bus.req_ready); end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      clken = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(i), 8'(3 - i));
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || in_flight !== 2'd3) begin
        errors++;
        $display("[TB] FAIL stall_frozen[%0d]: got ready=%b rsp_valid=%b in_flight=%0d, required 0000 0 3",
                 c, bus.req_ready, bus.rsp_valid, in_flight);
      end
    end
    @(negedge clock);
    clken = 1'b1;
    bus.req_valid = '0;
    drain();
    checks++;
    if (rsp_log.size() != 3) begin errors++; $display("[TB] FAIL stall_rsp_count: got %0d, required 3", rsp_log.size()); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      set_req(1, 1'b1, 8'(8'h40 + c), 8'h20);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rmid_launch[%0d]: got %b, required 0010", c, bus.req_ready); end
    end
    @(negedge clock);
    bus.req_valid = '0;
    aclr_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (in_flight !== 2'd0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_clear: got in_flight=%0d rsp_valid=%b, required 0 0", in_flight, bus.rsp_valid);
    end
    @(negedge clock);
    aclr_n = 1'b1;
    rsp_log.delete();
    repeat (5) @(negedge clock);
    checks++;
    if (rsp_log.size() != 0 || in_flight !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rmid_discard: got %0d responses in_flight=%0d, required 0 0", rsp_log.size(), in_flight);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h80 + i), 8'h81);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_priority: got %b, required 0001", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_equal();
    int         got;
    logic [1:0] id_e;
    logic [5:0] flags_e;
    got = 0; id_e = '0; flags_e = '0;
    @(negedge clock);
    set_req(3, 1'b1, 8'h3C, 8'h3C);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL equal_ready: got %b, required 1000", bus.req_ready); end
    @(negedge clock);
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (bus.rsp_valid === 1'b1) begin got++; id_e = bus.rsp_id; flags_e = bus.rsp_flags; end
      @(negedge clock);
    end
    checks++;
    if (got != 1 || id_e !== 2'd3 || flags_e !== 6'b010101) begin
      errors++;
      $display("[TB] FAIL equal_flags: got count=%0d id=%0d flags=%b, required 1 3 010101", got, id_e, flags_e);
    end
    drain();
  endtask

  initial begin
    aclr_n          = 1'b0;
    clken           = 1'b1;
    bus.req_valid   = '0;
    bus.req_dataa   = '0;
    bus.req_datab   = '0;
    bus_s.req_valid = '0;
    bus_s.req_dataa = '0;
    bus_s.req_datab = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_signed();
    test_stall();
    test_reset_mid();
    test_equal();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
